// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: shared direction encodings and effective-modulus helper.
//   DIR_UP / DIR_DOWN : encodings of the Up input
//   mod_eff()         : maps Modulus = 0 to 2^n, otherwise returns Modulus
package mod_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    localparam int   MAX_W    = 32;

    // Result is MAX_W+1 bits; callers cast it down to N+1 bits.
    function automatic logic [MAX_W:0] mod_eff(input logic [MAX_W-1:0] modulus, input int n);
        return (modulus == '0) ? ((MAX_W+1)'(1) << n) : {1'b0, modulus};
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// mod_counter_next: combinational successor, wrap and terminal flags for a modulo counter.
//   q_i       in  N  current count
//   up_i      in  1  direction (honoured only with MOD_COUNTER_DOWN_EN)
//   modulus_i in  N  modulus, 0 = 2^N
//   next_o    out N  value after an enabled edge
//   wrap_o    out 1  the enabled edge wraps (includes out-of-range recovery)
//   term_o    out 1  q_i is the terminal value for the current direction
// Macro: MOD_COUNTER_DOWN_EN builds the down path.
import mod_counter_pkg::*;

module mod_counter_next #(
    parameter int N = 8
) (
    input  logic [N-1:0] q_i,
    input  logic         up_i,
    input  logic [N-1:0] modulus_i,
    output logic [N-1:0] next_o,
    output logic         wrap_o,
    output logic         term_o
);

    logic [N:0]   m;
    logic [N-1:0] m_last;
    logic [N:0]   qx;
    logic         up_wrap;
    logic         dn_wrap;
    logic         dn;

    assign m       = (N+1)'(mod_eff(MAX_W'(modulus_i), N));
    assign m_last  = N'(m - (N+1)'(1));
    assign qx      = {1'b0, q_i};
    // ">=" rather than "==" pulls an out-of-range count back into range.
    assign up_wrap = qx >= {1'b0, m_last};
    assign dn_wrap = (q_i == '0) || (qx >= m);

`ifdef MOD_COUNTER_DOWN_EN
    assign dn = (up_i == DIR_DOWN);
`else
    logic unused_up;
    assign unused_up = up_i;
    assign dn = 1'b0;
`endif

    assign wrap_o = dn ? dn_wrap : up_wrap;
    assign next_o = dn ? (dn_wrap ? m_last : q_i - N'(1)) : (up_wrap ? '0 : q_i + N'(1));
    assign term_o = dn ? (q_i == '0) : (q_i == m_last);

endmodule

// File: rtl/mod_counter.sv
// mod_counter: cascadable programmable-modulus counter with clear, load and wrap pulse.
//   Clock      in  1  rising-edge clock
//   Reset_n    in  1  asynchronous active-low reset
//   Enable     in  1  count enable / cascade carry-in
//   Clear      in  1  synchronous clear to RESET_VALUE (highest priority)
//   Load       in  1  synchronous load of Load_Value
//   Load_Value in  N  value to load
//   Up         in  1  direction, 1 = up (used only with MOD_COUNTER_DOWN_EN)
//   Modulus    in  N  count range 0..Modulus-1, 0 = 2^N
//   Q          out N  registered count
//   Wrap       out 1  registered one-cycle wrap pulse
//   Carry_Out  out 1  Enable and Q at terminal value (combinational)
// Macro: MOD_COUNTER_DOWN_EN enables down-counting.
import mod_counter_pkg::*;

module mod_counter #(
    parameter int           N           = 8,
    parameter logic [N-1:0] RESET_VALUE = '0
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         Enable,
    input  logic         Clear,
    input  logic         Load,
    input  logic [N-1:0] Load_Value,
    input  logic         Up,
    input  logic [N-1:0] Modulus,
    output logic [N-1:0] Q,
    output logic         Wrap,
    output logic         Carry_Out
);

    logic [N-1:0] q_q, q_d, nxt;
    logic         wrap_q, wrap_d, nwrap, term;

    mod_counter_next #(.N(N)) u_next (
        .q_i       (q_q),
        .up_i      (Up),
        .modulus_i (Modulus),
        .next_o    (nxt),
        .wrap_o    (nwrap),
        .term_o    (term)
    );

    always_comb begin
        q_d    = Clear ? RESET_VALUE : Load ? Load_Value : Enable ? nxt : q_q;
        wrap_d = ~Clear & ~Load & Enable & nwrap;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            q_q    <= RESET_VALUE;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q         = q_q;
    assign Wrap      = wrap_q;
    assign Carry_Out = Enable & term;

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed vector bench for mod_counter, plus cascade and 2^N wrap sequences.
module tb_mod_counter;

    typedef struct {
        logic       clr, ld, en, up;
        logic [3:0] lv, md;
        logic [3:0] q;
        logic       w, co;
    } vec_t;

    logic       Clock = 1'b0;
    logic       Reset_n, rst_c_n;
    logic       Enable, Clear, Load, Up;
    logic [3:0] Load_Value, Modulus;
    logic [3:0] Q;
    logic       Wrap, Carry_Out;

    logic [3:0] lo_q, hi_q;
    logic       lo_w, hi_w, lo_co, hi_co;
    logic [2:0] q3;
    logic       w3, co3;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 Clock = ~Clock;

    mod_counter #(.N(4), .RESET_VALUE(4'd3)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Clear(Clear), .Load(Load),
        .Load_Value(Load_Value), .Up(Up), .Modulus(Modulus),
        .Q(Q), .Wrap(Wrap), .Carry_Out(Carry_Out)
    );

    mod_counter #(.N(4), .RESET_VALUE(4'd0)) u_lo (
        .Clock(Clock), .Reset_n(rst_c_n), .Enable(1'b1), .Clear(1'b0), .Load(1'b0),
        .Load_Value(4'd0), .Up(1'b1), .Modulus(4'd10),
        .Q(lo_q), .Wrap(lo_w), .Carry_Out(lo_co)
    );

    mod_counter #(.N(4), .RESET_VALUE(4'd0)) u_hi (
        .Clock(Clock), .Reset_n(rst_c_n), .Enable(lo_co), .Clear(1'b0), .Load(1'b0),
        .Load_Value(4'd0), .Up(1'b1), .Modulus(4'd10),
        .Q(hi_q), .Wrap(hi_w), .Carry_Out(hi_co)
    );

    mod_counter #(.N(3), .RESET_VALUE(3'd0)) u3 (
        .Clock(Clock), .Reset_n(rst_c_n), .Enable(1'b1), .Clear(1'b0), .Load(1'b0),
        .Load_Value(3'd0), .Up(1'b1), .Modulus(3'd0),
        .Q(q3), .Wrap(w3), .Carry_Out(co3)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic vec_t v(input logic clr, ld, en, up, input logic [3:0] lv, md, q,
                               input logic w, co);
        vec_t r;
        r.clr = clr; r.ld = ld; r.en = en; r.up = up; r.lv = lv; r.md = md;
        r.q = q; r.w = w; r.co = co;
        return r;
    endfunction

    initial begin
        vecs.push_back(v(1, 0, 0, 1, 0, 10, 3, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 0, 10, 0, 0, 0));
        for (int i = 1; i <= 9; i++) vecs.push_back(v(0, 0, 1, 1, 0, 10, 4'(i), 0, i == 9));
        vecs.push_back(v(0, 0, 1, 1, 0, 10, 0, 1, 0));
        vecs.push_back(v(0, 0, 1, 1, 0, 10, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 12, 10, 12, 0, 0));
        vecs.push_back(v(0, 0, 1, 1, 0, 10, 0, 1, 0));
        vecs.push_back(v(1, 1, 1, 1, 9, 10, 3, 0, 0));
        vecs.push_back(v(0, 1, 1, 1, 9, 10, 9, 0, 1));
        vecs.push_back(v(0, 0, 0, 1, 0, 10, 9, 0, 0));
        vecs.push_back(v(0, 1, 1, 1, 15, 0, 15, 0, 1));
        vecs.push_back(v(0, 0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 1, 1, 0, 1, 0, 1, 1));
        vecs.push_back(v(0, 0, 1, 1, 0, 1, 0, 1, 1));
`ifdef MOD_COUNTER_DOWN_EN
        vecs.push_back(v(0, 1, 0, 0, 2, 6, 2, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 6, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 6, 0, 0, 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 6, 5, 1, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 6, 4, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 12, 10, 12, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 10, 9, 1, 0));
`else
        vecs.push_back(v(0, 1, 0, 1, 4, 10, 4, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 10, 5, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 9, 10, 9, 0, 1));
`endif

        Reset_n = 1'b1; rst_c_n = 1'b1;
        Enable = 1'b0; Clear = 1'b0; Load = 1'b0; Up = 1'b1;
        Load_Value = 4'd0; Modulus = 4'd10;
        #1 Reset_n = 1'b0; rst_c_n = 1'b0;
        #1;
        chk("reset_q", Q, 3);
        chk("reset_wrap", Wrap, 0);
        @(negedge Clock) Reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge Clock);
            Clear = vecs[i].clr; Load = vecs[i].ld; Enable = vecs[i].en; Up = vecs[i].up;
            Load_Value = vecs[i].lv; Modulus = vecs[i].md;
            @(posedge Clock);
            #1;
            chk($sformatf("vec%0d_q", i), Q, vecs[i].q);
            chk($sformatf("vec%0d_wrap", i), Wrap, vecs[i].w);
            chk($sformatf("vec%0d_carry", i), Carry_Out, vecs[i].co);
        end

        @(negedge Clock);
        Clear = 1'b0; Load = 1'b0; Enable = 1'b1; Up = 1'b1; Modulus = 4'd1;
        @(posedge Clock);
        #1;
        chk("m1_wrap", Wrap, 1);
        #1 Reset_n = 1'b0;
        #1;
        chk("midreset_q", Q, 3);
        chk("midreset_wrap", Wrap, 0);
        @(negedge Clock) Reset_n = 1'b1; Enable = 1'b0;
        @(posedge Clock);
        #1;
        chk("postreset_wrap", Wrap, 0);

        @(negedge Clock) rst_c_n = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge Clock);
            #1;
            chk("casc_lo_q", lo_q, k % 10);
            chk("casc_hi_q", hi_q, (k / 10) % 10);
            chk("casc_lo_wrap", lo_w, (k % 10) == 0);
            chk("casc_hi_wrap", hi_w, (k % 100) == 0);
            chk("n3_q", q3, k % 8);
            chk("n3_wrap", w3, (k % 8) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
